// File: rtl/cla_adder_checker_if.sv
// rtl/cla_adder_checker_if.sv - operand/result bundle between checker and adder under test
//
// Purpose : groups the adder-facing signals of cla_adder_checker.
// Signals : a_out, b_out, cin_out - operands driven toward the adder
//           sum_in, cout_in       - result returned by the adder
// Modports: master - checker side (drives operands, receives result)
//           slave  - adder side (receives operands, drives result)

interface cla_adder_checker_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             cin_out;
    logic [WIDTH-1:0] sum_in;
    logic             cout_in;

    modport master (
        output a_out,
        output b_out,
        output cin_out,
        input  sum_in,
        input  cout_in
    );

    modport slave (
        input  a_out,
        input  b_out,
        input  cin_out,
        output sum_in,
        output cout_in
    );
endinterface

// File: rtl/cla_adder_checker.sv
// rtl/cla_adder_checker.sv - exhaustive stimulus generator and checker for WIDTH-bit adders
//
// Purpose : walks every {cin, a, b} combination into an adder under test, compares
//           {cout, sum} with a+b+cin, counts mismatches and captures the first one.
// Ports   : clk, rst_n    - clock, synchronous active-low reset
//           start         - begin a run (honoured only in IDLE or DONE)
//           adder         - operands out / result in (master side)
//           busy, done    - run in progress / run finished
//           pass          - done with zero mismatches
//           err_count     - saturating mismatch count
//           fail_valid    - first-failure capture is populated
//           fail_vec      - vector index of the first failure
//           fail_got      - {cout, sum} returned at the first failure

module cla_adder_checker #(
    parameter int WIDTH = 4,
    parameter int LAT   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    cla_adder_checker_if.master   adder,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic                  fail_valid,
    output logic [2*WIDTH:0]      fail_vec,
    output logic [WIDTH:0]        fail_got
);
    localparam int VW  = 2 * WIDTH + 1;
    localparam int WCW = 4;

    // Terminal index N-1 is all ones; the run ends on equality, never on wrap.
    localparam logic [VW-1:0] VEC_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q,      state_d;
    logic [VW-1:0]    vec_q,        vec_d;
    logic [WCW-1:0]   wcnt_q,       wcnt_d;
    logic [WIDTH-1:0] a_q,          a_d;
    logic [WIDTH-1:0] b_q,          b_d;
    logic             cin_q,        cin_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;
    logic             pass_q,       pass_d;
    logic [15:0]      err_q,        err_d;
    logic             fail_valid_q, fail_valid_d;
    logic [VW-1:0]    fail_vec_q,   fail_vec_d;
    logic [WIDTH:0]   fail_got_q,   fail_got_d;

    logic [WIDTH:0]   got;
    logic [WIDTH:0]   expected;
    logic             mismatch;

    // Operands are held in a_q/b_q/cin_q through CHECK, so the reference sum is
    // taken from them rather than re-decoding vec.
    always_comb begin
        got      = {adder.cout_in, adder.sum_in};
        expected = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        mismatch = (got != expected);
    end

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        wcnt_d       = wcnt_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        fail_got_d   = fail_got_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    vec_d        = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                    fail_got_d   = '0;
                    state_d      = S_APPLY;
                end
            end

            S_APPLY: begin
                cin_d  = vec_q[VW-1];
                a_d    = vec_q[2*WIDTH-1:WIDTH];
                b_d    = vec_q[WIDTH-1:0];
                wcnt_d = WCW'(LAT);
                state_d = (LAT > 0) ? S_SETTLE : S_CHECK;
            end

            // wcnt counts the remaining pipeline edges; leave on the edge where
            // it reads 1 so SETTLE lasts exactly LAT cycles.
            S_SETTLE: begin
                wcnt_d = wcnt_q - 1'b1;
                if (wcnt_q == WCW'(1)) begin
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_vec_d   = vec_q;
                        fail_got_d   = got;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = S_APPLY;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they change on
        // the same edge as the state itself (busy falls as done rises).
        busy_d = (state_d == S_APPLY) || (state_d == S_SETTLE) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == 16'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            wcnt_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            fail_got_q   <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            wcnt_q       <= wcnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            fail_got_q   <= fail_got_d;
        end
    end

    assign adder.a_out   = a_q;
    assign adder.b_out   = b_q;
    assign adder.cin_out = cin_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign fail_valid    = fail_valid_q;
    assign fail_vec      = fail_vec_q;
    assign fail_got      = fail_got_q;

endmodule

// File: tb/tb_cla_adder_checker.sv
// tb/tb_cla_adder_checker.sv - scoreboard bench for cla_adder_checker

module tb_cla_adder_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0;
    logic start2 = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mode0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cla_adder_checker_if #(.WIDTH(4)) bus0 ();
    cla_adder_checker_if #(.WIDTH(4)) bus2 ();

    logic        busy0, done0, pass0, fv0;
    logic [15:0] err0;
    logic [8:0]  fvec0;
    logic [4:0]  fgot0;
    logic        busy2, done2, pass2, fv2;
    logic [15:0] err2;
    logic [8:0]  fvec2;
    logic [4:0]  fgot2;

    cla_adder_checker #(.WIDTH(4), .LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .adder(bus0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_valid(fv0), .fail_vec(fvec0), .fail_got(fgot0)
    );

    cla_adder_checker #(.WIDTH(4), .LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .adder(bus2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_valid(fv2), .fail_vec(fvec2), .fail_got(fgot2)
    );

    // Adder models: mode 0 correct, 1 sum[0] stuck-at-0, 2 cout inverted,
    // 3 two-stage pipelined adder.
    logic [4:0] t0, p0_1, p0_2, res0;
    logic [4:0] t2, p2_1, p2_2;
    assign t0 = {1'b0, bus0.a_out} + {1'b0, bus0.b_out} + {4'b0, bus0.cin_out};
    assign t2 = {1'b0, bus2.a_out} + {1'b0, bus2.b_out} + {4'b0, bus2.cin_out};
    always @(posedge clk) begin
        p0_1 <= t0;
        p0_2 <= p0_1;
        p2_1 <= t2;
        p2_2 <= p2_1;
    end
    always_comb begin
        res0 = t0;
        case (mode0)
            1:       res0 = t0 & 5'b11110;
            2:       res0 = t0 ^ 5'b10000;
            3:       res0 = p0_2;
            default: res0 = t0;
        endcase
    end
    assign {bus0.cout_in, bus0.sum_in} = res0;
    assign {bus2.cout_in, bus2.sum_in} = p2_2;

    typedef struct {
        int   start_edge;
        int   done_edge;
        int   err;
        logic exact;
        logic fv;
        int   fvec;
        int   fgot;
        logic pass;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    task automatic check_done(input string tag, input exp_t e, input logic busy,
                              input logic pass, input logic [15:0] err, input logic fv,
                              input logic [8:0] fvec, input logic [4:0] fgot);
        chk({tag, "_done_edge"}, cyc - e.start_edge, e.done_edge);
        chk({tag, "_busy_at_done"}, {31'b0, busy}, 0);
        chk({tag, "_pass"}, {31'b0, pass}, {31'b0, e.pass});
        if (e.exact) begin
            chk({tag, "_err_count"}, {16'b0, err}, e.err);
            chk({tag, "_fail_valid"}, {31'b0, fv}, {31'b0, e.fv});
            if (e.fv) begin
                chk({tag, "_fail_vec"}, {23'b0, fvec}, e.fvec);
                chk({tag, "_fail_got"}, {27'b0, fgot}, e.fgot);
            end
        end else begin
            chk({tag, "_err_nonzero"}, {31'b0, err != 16'd0}, 1);
        end
    endtask

    // Monitors: pop an expectation whenever a checker raises done.
    logic done0_prev = 1'b0;
    logic done2_prev = 1'b0;
    always @(negedge clk) begin
        if (done0 === 1'b1 && !done0_prev) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_done", 1, 0);
            end else begin
                check_done("dut0", q0.pop_front(), busy0, pass0, err0, fv0, fvec0, fgot0);
            end
        end
        done0_prev = (done0 === 1'b1);
        if (done2 === 1'b1 && !done2_prev) begin
            if (q2.size() == 0) begin
                chk("dut2_unexpected_done", 1, 0);
            end else begin
                check_done("dut2", q2.pop_front(), busy2, pass2, err2, fv2, fvec2, fgot2);
            end
        end
        done2_prev = (done2 === 1'b1);
    end

    function automatic exp_t mk(input int done_edge, input int err, input logic exact,
                                input logic fv, input int fvec, input int fgot, input logic pass);
        exp_t e;
        e.start_edge = 0;
        e.done_edge  = done_edge;
        e.err        = err;
        e.exact      = exact;
        e.fv         = fv;
        e.fvec       = fvec;
        e.fgot       = fgot;
        e.pass       = pass;
        return e;
    endfunction

    task automatic issue(input int dut, input exp_t e, input logic push);
        @(negedge clk);
        if (dut == 0) start0 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start2 = 1'b0;
        e.start_edge = cyc;
        if (dut == 0) begin
            chk("edge0_busy", {31'b0, busy0}, 1);
            chk("edge0_done", {31'b0, done0}, 0);
            chk("edge0_err_clear", {16'b0, err0}, 0);
            chk("edge0_fv_clear", {31'b0, fv0}, 0);
            if (push) q0.push_back(e);
        end else begin
            chk("edge0_busy2", {31'b0, busy2}, 1);
            if (push) q2.push_back(e);
        end
    endtask

    task automatic drain(input int dut);
        int n;
        n = 0;
        while (((dut == 0) ? q0.size() : q2.size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", (dut == 0) ? q0.size() : q2.size(), 0);
        @(negedge clk);
    endtask

    task automatic wait_vec0(input logic [8:0] v);
        int n;
        n = 0;
        while (!(bus0.cin_out === v[8] && bus0.a_out === v[7:4] && bus0.b_out === v[3:0]) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_vec_timeout", (n < 3000) ? 0 : 1, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a"}, {28'b0, bus0.a_out}, 0);
        chk({tag, "_b"}, {28'b0, bus0.b_out}, 0);
        chk({tag, "_cin"}, {31'b0, bus0.cin_out}, 0);
        chk({tag, "_busy"}, {31'b0, busy0}, 0);
        chk({tag, "_done"}, {31'b0, done0}, 0);
        chk({tag, "_pass"}, {31'b0, pass0}, 0);
        chk({tag, "_err"}, {16'b0, err0}, 0);
        chk({tag, "_fv"}, {31'b0, fv0}, 0);
        chk({tag, "_fvec"}, {23'b0, fvec0}, 0);
        chk({tag, "_fgot"}, {27'b0, fgot0}, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Correct combinational adder, with a start pulse at vec=50 that must be ignored.
        mode0 = 0;
        issue(0, mk(1024, 0, 1'b1, 1'b0, 0, 0, 1'b1), 1'b1);
        wait_vec0(9'd50);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        drain(0);

        // sum[0] stuck-at-0: every vector with an odd total fails.
        mode0 = 1;
        issue(0, mk(1024, 256, 1'b1, 1'b1, 9'h001, 5'b00000, 1'b0), 1'b1);
        drain(0);

        // Restart from DONE against a correct adder clears the failure state.
        mode0 = 0;
        issue(0, mk(1024, 0, 1'b1, 1'b0, 0, 0, 1'b1), 1'b1);
        drain(0);

        // cout inverted: all 512 vectors fail, first at vec 0 with result 0 -> 5'b10000.
        mode0 = 2;
        issue(0, mk(1024, 512, 1'b1, 1'b1, 9'h000, 5'b10000, 1'b0), 1'b1);
        drain(0);

        // Pipelined adder checked with LAT=0 must fail.
        mode0 = 3;
        issue(0, mk(1024, 0, 1'b0, 1'b0, 0, 0, 1'b0), 1'b1);
        drain(0);

        // Pipelined adder with matching LAT=2.
        issue(2, mk(2048, 0, 1'b1, 1'b0, 0, 0, 1'b1), 1'b1);
        drain(2);

        // Reset mid-run at vec=100, then a stray-free idle period, then a fresh run.
        mode0 = 0;
        issue(0, mk(0, 0, 1'b0, 1'b0, 0, 0, 1'b0), 1'b0);
        wait_vec0(9'd100);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_after_reset_busy", {31'b0, busy0}, 0);
        chk("idle_after_reset_done", {31'b0, done0}, 0);
        issue(0, mk(1024, 0, 1'b1, 1'b0, 0, 0, 1'b1), 1'b1);
        drain(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
